// File: rtl/instruction_queue_if.sv
// Fetch-side pair input, decoder-side single-word output and queue status for instruction_queue.
interface instruction_queue_if #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
);
    logic             flush;
    logic             in_valid;
    logic [31:0]      in_instr1;
    logic [31:0]      in_instr2;
    logic             in_done;
    logic             in_ready;
    logic             out_valid;
    logic [31:0]      out_instr;
    logic             out_ready;
    logic [PTR_W:0]   count;
    logic             drained;

    modport master (
        output flush, in_valid, in_instr1, in_instr2, in_done, out_ready,
        input  in_ready, out_valid, out_instr, count, drained
    );

    modport slave (
        input  flush, in_valid, in_instr1, in_instr2, in_done, out_ready,
        output in_ready, out_valid, out_instr, count, drained
    );
endinterface

// File: rtl/instruction_queue.sv
// Circular instruction buffer: accepts fetch pairs (dropping zero words), issues one word per cycle.
// Latency: one cycle, no bypass. Backpressure: in_ready drops below 2 free slots or once in_done is seen.
module instruction_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    instruction_queue_if.slave q
);
    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [31:0]      mem_q [DEPTH];

    logic             accept;
    logic             wr1;
    logic             wr2;
    logic             deq;
    logic [PTR_W:0]   n_wr;
    logic [PTR_W-1:0] wr2_addr;

    assign q.in_ready  = (state_q == RUN) && (count_q <= (PTR_W+1)'(DEPTH - 2));
    assign q.out_valid = (count_q != '0);
    assign q.out_instr = q.out_valid ? mem_q[rd_ptr_q] : 32'b0;
    assign q.count     = count_q;
    assign q.drained   = (state_q == DONE);

    // A pair arriving alongside flush belongs to the squashed path, so it never writes.
    assign accept   = q.in_valid && q.in_ready && !q.flush;
    assign wr1      = accept && (q.in_instr1 != 32'b0);
    assign wr2      = accept && (q.in_instr2 != 32'b0);
    assign deq      = q.out_valid && q.out_ready;
    assign n_wr     = (PTR_W+1)'(wr1) + (PTR_W+1)'(wr2);
    assign wr2_addr = wr_ptr_q + PTR_W'(wr1);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(n_wr);
        rd_ptr_d = rd_ptr_q + PTR_W'(deq);
        count_d  = count_q + n_wr - (PTR_W+1)'(deq);

        case (state_q)
            RUN: begin
                if (q.in_done) begin
                    state_d = (count_d == '0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (count_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase

        if (q.flush) begin
            state_d  = RUN;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never cleared; the pointers alone say which slots are live.
    always_ff @(posedge clk) begin
        if (wr1) begin
            mem_q[wr_ptr_q] <= q.in_instr1;
        end
        if (wr2) begin
            mem_q[wr2_addr] <= q.in_instr2;
        end
    end
endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue.
module tb_instruction_queue;
    localparam int DEPTH = 8;
    localparam int PTR_W = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   tests_run = 0;
    int   fails = 0;

    instruction_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

    instruction_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .q     (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr1 = 32'b0;
        bus.in_instr2 = 32'b0;
        bus.in_done   = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pair(input logic [31:0] a, input logic [31:0] b);
        bus.in_valid  = 1'b1;
        bus.in_instr1 = a;
        bus.in_instr2 = b;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_instr !== 32'b0) begin fails++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL reset_count got %0d want 0", bus.count); end
        tests_run++; if (bus.drained !== 1'b0) begin fails++; $display("FAIL reset_drained got %b want 0", bus.drained); end
    endtask

    task automatic test_fill();
        pair(32'h00100093, 32'h00200113);
        cycle();
        pair(32'h00300193, 32'h00400213);
        cycle();
        idle();
        tests_run++; if (bus.count !== 4'd4) begin fails++; $display("FAIL fill_count got %0d want 4", bus.count); end
        tests_run++; if (bus.out_instr !== 32'h00100093) begin fails++; $display("FAIL fill_head got %h want 00100093", bus.out_instr); end
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL fill_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_full();
        logic [31:0] exp_w [7];
        exp_w = '{32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293,
                  32'h00600313, 32'h00700393, 32'h00800413};
        pair(32'h00500293, 32'h00600313);
        cycle();
        tests_run++; if (bus.count !== 4'd6) begin fails++; $display("FAIL full_count6 got %0d want 6", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL full_ready6 got %b want 1", bus.in_ready); end
        pair(32'h00700393, 32'h00800413);
        cycle();
        tests_run++; if (bus.count !== 4'd8) begin fails++; $display("FAIL full_count8 got %0d want 8", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready8 got %b want 0", bus.in_ready); end
        pair(32'hDEAD0001, 32'hDEAD0002);
        bus.out_ready = 1'b1;
        cycle();
        tests_run++; if (bus.count !== 4'd7) begin fails++; $display("FAIL full_count7 got %0d want 7", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL full_ready7 got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b0;
        cycle();
        tests_run++; if (bus.count !== 4'd7) begin fails++; $display("FAIL full_hold7 got %0d want 7", bus.count); end
        idle();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            #1;
            tests_run++; if (bus.out_instr !== exp_w[i]) begin fails++; $display("FAIL full_order[%0d] got %h want %h", i, bus.out_instr, exp_w[i]); end
            cycle();
        end
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL full_empty_count got %0d want 0", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL full_empty_valid got %b want 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_nop_drop();
        do_reset();
        bus.out_ready = 1'b1;
        pair(32'h00500293, 32'h0);
        cycle();
        tests_run++; if (bus.count !== 4'd1) begin fails++; $display("FAIL nop_count_a got %0d want 1", bus.count); end
        tests_run++; if (bus.out_instr !== 32'h00500293) begin fails++; $display("FAIL nop_word_a got %h want 00500293", bus.out_instr); end
        pair(32'h0, 32'h00600313);
        cycle();
        tests_run++; if (bus.count !== 4'd1) begin fails++; $display("FAIL nop_count_b got %0d want 1", bus.count); end
        tests_run++; if (bus.out_instr !== 32'h00600313) begin fails++; $display("FAIL nop_word_b got %h want 00600313", bus.out_instr); end
        idle();
        bus.out_ready = 1'b1;
        cycle();
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL nop_count_c got %0d want 0", bus.count); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL nop_valid_c got %b want 0", bus.out_valid); end
        idle();
    endtask

    task automatic test_wrap();
        logic [31:0] sb [$];
        int   cnt_m = 0;
        int   sent = 0;
        int   recvd = 0;
        int   n = 0;
        logic exp_rdy;
        logic did_deq;
        logic [31:0] w1;
        logic [31:0] w2;
        do_reset();
        while (recvd < 40 && n < 400) begin
            bus.out_ready = n[0];
            exp_rdy = (cnt_m <= DEPTH - 2);
            w1 = 32'h10000000 | 32'(2 * sent + 1);
            w2 = 32'h10000000 | 32'(2 * sent + 2);
            if (sent < 20) pair(w1, w2);
            else bus.in_valid = 1'b0;
            #1;
            tests_run++; if (bus.in_ready !== exp_rdy) begin fails++; $display("FAIL wrap_ready cyc %0d got %b want %b", n, bus.in_ready, exp_rdy); end
            did_deq = 1'b0;
            if (bus.out_ready && cnt_m != 0) begin
                tests_run++; if (bus.out_instr !== sb[0]) begin fails++; $display("FAIL wrap_word %0d got %h want %h", recvd, bus.out_instr, sb[0]); end
                void'(sb.pop_front());
                recvd++;
                did_deq = 1'b1;
            end
            if (bus.in_valid && exp_rdy) begin
                sb.push_back(w1);
                sb.push_back(w2);
                sent++;
                cnt_m += 2;
            end
            if (did_deq) cnt_m -= 1;
            cycle();
            tests_run++; if (bus.count !== 4'(cnt_m)) begin fails++; $display("FAIL wrap_count cyc %0d got %0d want %0d", n, bus.count, cnt_m); end
            n++;
        end
        tests_run++; if (recvd != 40) begin fails++; $display("FAIL wrap_timeout got %0d words want 40", recvd); end
        idle();
    endtask

    task automatic test_drain();
        logic [31:0] exp_w [5];
        exp_w = '{32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, 32'h00500293};
        do_reset();
        pair(32'h00100093, 32'h00200113);
        cycle();
        pair(32'h00300193, 32'h0);
        cycle();
        tests_run++; if (bus.count !== 4'd3) begin fails++; $display("FAIL drain_count3 got %0d want 3", bus.count); end
        pair(32'h00400213, 32'h00500293);
        bus.in_done = 1'b1;
        cycle();
        bus.in_done = 1'b0;
        tests_run++; if (bus.count !== 4'd5) begin fails++; $display("FAIL drain_count5 got %0d want 5", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL drain_ready got %b want 0", bus.in_ready); end
        tests_run++; if (bus.drained !== 1'b0) begin fails++; $display("FAIL drain_early got %b want 0", bus.drained); end
        pair(32'hBAD00001, 32'hBAD00002);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++; if (bus.out_instr !== exp_w[i]) begin fails++; $display("FAIL drain_order[%0d] got %h want %h", i, bus.out_instr, exp_w[i]); end
            cycle();
        end
        tests_run++; if (bus.drained !== 1'b1) begin fails++; $display("FAIL drain_done got %b want 1", bus.drained); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drain_valid got %b want 0", bus.out_valid); end
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL drain_count0 got %0d want 0", bus.count); end
        idle();
        cycle();
        tests_run++; if (bus.drained !== 1'b1) begin fails++; $display("FAIL drain_hold got %b want 1", bus.drained); end
        tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL done_ready got %b want 0", bus.in_ready); end
    endtask

    task automatic test_flush();
        do_reset();
        pair(32'h00100093, 32'h00200113);
        cycle();
        pair(32'h00300193, 32'h00400213);
        cycle();
        pair(32'h00500293, 32'h00600313);
        cycle();
        tests_run++; if (bus.count !== 4'd6) begin fails++; $display("FAIL flush_pre got %0d want 6", bus.count); end
        pair(32'hDEAD0003, 32'hDEAD0004);
        bus.flush     = 1'b1;
        bus.out_ready = 1'b1;
        bus.in_done   = 1'b1;
        cycle();
        idle();
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL flush_count got %0d want 0", bus.count); end
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_run got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL flush_valid got %b want 0", bus.out_valid); end
        pair(32'h00900493, 32'h00a00513);
        cycle();
        idle();
        tests_run++; if (bus.count !== 4'd2) begin fails++; $display("FAIL postflush_count got %0d want 2", bus.count); end
        tests_run++; if (bus.out_instr !== 32'h00900493) begin fails++; $display("FAIL postflush_head got %h want 00900493", bus.out_instr); end
        bus.in_done = 1'b1;
        cycle();
        bus.in_done = 1'b0;
        tests_run++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL middrain_ready got %b want 0", bus.in_ready); end
        #2;
        reset = 1'b1;
        #1;
        tests_run++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rst_drain_ready got %b want 1", bus.in_ready); end
        tests_run++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_drain_valid got %b want 0", bus.out_valid); end
        tests_run++; if (bus.out_instr !== 32'b0) begin fails++; $display("FAIL rst_drain_instr got %h want 0", bus.out_instr); end
        tests_run++; if (bus.count !== 4'd0) begin fails++; $display("FAIL rst_drain_count got %0d want 0", bus.count); end
        tests_run++; if (bus.drained !== 1'b0) begin fails++; $display("FAIL rst_drain_drained got %b want 0", bus.drained); end
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        idle();
        test_reset();
        test_fill();
        test_full();
        test_nop_drop();
        test_wrap();
        test_drain();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule
